// File: rtl/count_mon_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | count_mon_pkg : shared types and constants for count_stream_monitor   |
// | Revision      : 1.0                                                   |
// +----------------------------------------------------------------------+
package count_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    FAIL = 2'd3
  } mon_state_t;

  localparam int ERR_W   = 8;
  localparam int ERR_MAX = 255;

endpackage
`default_nettype wire

// File: rtl/count_stream_monitor_gap_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gap_timer : counts consecutive idle cycles while enabled, flags the   |
// |             TIMEOUT-th idle cycle.      Revision : 1.0                |
// +----------------------------------------------------------------------+
module gap_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  input  logic kick,
  output logic expired
);

  localparam int            CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en || kick) begin
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires on the idle cycle that would take the count past TIMEOUT-1.
  assign expired = en && !kick && (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/count_stream_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | count_stream_monitor : checks a valid-qualified +1 counter stream     |
// |                        from 0, ends in DONE or FAIL. Revision : 1.0   |
// +----------------------------------------------------------------------+
module count_stream_monitor
  import count_mon_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int HIT_A     = 30,
  parameter int HIT_B     = 300,
  parameter int END_VALUE = 499,
  parameter int TIMEOUT   = 1024,
  parameter int MAX_ERR   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample_data,
  output logic [1:0]       state_o,
  output logic             hit_a,
  output logic             hit_b,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] samples_seen,
  output logic             done,
  output logic             fail
);

  localparam logic [WIDTH-1:0] HIT_A_V = WIDTH'(HIT_A);
  localparam logic [WIDTH-1:0] HIT_B_V = WIDTH'(HIT_B);
  localparam logic [WIDTH-1:0] END_V   = WIDTH'(END_VALUE);
  localparam logic [ERR_W-1:0] ERR_SAT = ERR_W'(ERR_MAX);

  mon_state_t       state_q, state_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic [WIDTH-1:0] samples_q, samples_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             hit_a_q, hit_a_d;
  logic             hit_b_q, hit_b_d;

  logic             w_accept;
  logic             w_mismatch;
  logic [ERR_W-1:0] w_err_next;
  logic             w_expired;

  gap_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_gap_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .en      (state_q == RUN),
    .kick    (sample_valid),
    .expired (w_expired)
  );

  // IDLE samples are handled exactly like RUN samples; expected is 0 there.
  assign w_accept   = sample_valid && ((state_q == IDLE) || (state_q == RUN));
  assign w_mismatch = (sample_data != expected_q);
  assign w_err_next = (w_mismatch && (err_q != ERR_SAT)) ? err_q + 1'b1 : err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else if (clear) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RUN: begin
        if (w_accept) begin
          if (int'(w_err_next) >= MAX_ERR) begin
            state_d = FAIL;
          end else if (sample_data == END_V) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end else if (w_expired) begin
          state_d = FAIL;
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    state_o = state_q;
    done    = (state_q == DONE);
    fail    = (state_q == FAIL);
  end

  always_comb begin
    expected_d = expected_q;
    samples_d  = samples_q;
    err_d      = err_q;
    hit_a_d    = hit_a_q;
    hit_b_d    = hit_b_q;
    if (w_accept) begin
      expected_d = sample_data + 1'b1;
      samples_d  = samples_q + 1'b1;
      err_d      = w_err_next;
      if (sample_data == HIT_A_V) hit_a_d = 1'b1;
      if (sample_data == HIT_B_V) hit_b_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      expected_q <= '0;
      samples_q  <= '0;
      err_q      <= '0;
      hit_a_q    <= 1'b0;
      hit_b_q    <= 1'b0;
    end else if (clear) begin
      expected_q <= '0;
      samples_q  <= '0;
      err_q      <= '0;
      hit_a_q    <= 1'b0;
      hit_b_q    <= 1'b0;
    end else begin
      expected_q <= expected_d;
      samples_q  <= samples_d;
      err_q      <= err_d;
      hit_a_q    <= hit_a_d;
      hit_b_q    <= hit_b_d;
    end
  end

  assign hit_a        = hit_a_q;
  assign hit_b        = hit_b_q;
  assign err_count    = err_q;
  assign samples_seen = samples_q;

endmodule
`default_nettype wire

// File: tb/tb_count_stream_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_count_stream_monitor : scoreboard bench for count_stream_monitor   |
// | Revision                : 1.0                                         |
// +----------------------------------------------------------------------+
module tb_count_stream_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: 32-bit stream, TIMEOUT=16, MAX_ERR=8
  logic        reset0, clear0, sv0;
  logic [31:0] sd0;
  logic [1:0]  st0;
  logic        ha0, hb0, dn0, fl0;
  logic [7:0]  err0;
  logic [31:0] smp0;

  // Instance 1: 8-bit stream for the wrap case
  logic        reset1, clear1, sv1;
  logic [7:0]  sd1;
  logic [1:0]  st1;
  logic        ha1, hb1, dn1, fl1;
  logic [7:0]  err1;
  logic [7:0]  smp1;

  count_stream_monitor #(
    .WIDTH(32), .HIT_A(30), .HIT_B(300), .END_VALUE(499), .TIMEOUT(16), .MAX_ERR(8)
  ) dut0 (
    .clk(clk), .reset(reset0), .clear(clear0), .sample_valid(sv0), .sample_data(sd0),
    .state_o(st0), .hit_a(ha0), .hit_b(hb0), .err_count(err0), .samples_seen(smp0),
    .done(dn0), .fail(fl0)
  );

  count_stream_monitor #(
    .WIDTH(8), .HIT_A(200), .HIT_B(255), .END_VALUE(3), .TIMEOUT(16), .MAX_ERR(8)
  ) dut1 (
    .clk(clk), .reset(reset1), .clear(clear1), .sample_valid(sv1), .sample_data(sd1),
    .state_o(st1), .hit_a(ha1), .hit_b(hb1), .err_count(err1), .samples_seen(smp1),
    .done(dn1), .fail(fl1)
  );

  typedef struct {
    int          sel;
    logic [1:0]  st;
    logic        ha;
    logic        hb;
    logic [7:0]  err;
    logic [31:0] smp;
    logic        dn;
    logic        fl;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    compared   = 0;
  int    mismatched = 0;

  task automatic expect_out(input int sel, input string name, input logic [1:0] st,
                            input logic ha, input logic hb, input logic [7:0] err,
                            input logic [31:0] smp, input logic dn, input logic fl);
    exp_t e;
    e.sel = sel; e.st = st; e.ha = ha; e.hb = hb;
    e.err = err; e.smp = smp; e.dn = dn; e.fl = fl;
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  task automatic chk(input string name, input string field, input logic [31:0] act,
                     input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s.%s: got %0d, required %0d", name, field, act, req);
    end
  endtask

  // Monitor: drains pending expectations at each falling edge.
  initial begin
    exp_t  e;
    string n;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (e.sel == 0) begin
          chk(n, "state", 32'(st0), 32'(e.st));
          chk(n, "hit_a", 32'(ha0), 32'(e.ha));
          chk(n, "hit_b", 32'(hb0), 32'(e.hb));
          chk(n, "err",   32'(err0), 32'(e.err));
          chk(n, "samples", smp0, e.smp);
          chk(n, "done",  32'(dn0), 32'(e.dn));
          chk(n, "fail",  32'(fl0), 32'(e.fl));
        end else begin
          chk(n, "state", 32'(st1), 32'(e.st));
          chk(n, "hit_a", 32'(ha1), 32'(e.ha));
          chk(n, "hit_b", 32'(hb1), 32'(e.hb));
          chk(n, "err",   32'(err1), 32'(e.err));
          chk(n, "samples", 32'(smp1), e.smp);
          chk(n, "done",  32'(dn1), 32'(e.dn));
          chk(n, "fail",  32'(fl1), 32'(e.fl));
        end
      end
    end
  end

  task automatic d0(input logic v, input logic [31:0] d);
    sv0 = v; sd0 = d;
    @(posedge clk); #1;
  endtask

  task automatic run0(input int a, input int b);
    for (int i = a; i <= b; i++) d0(1'b1, 32'(i));
    sv0 = 1'b0;
  endtask

  task automatic clr0();
    clear0 = 1'b1; sv0 = 1'b1; sd0 = 32'd77;
    @(posedge clk); #1;
    clear0 = 1'b0; sv0 = 1'b0;
  endtask

  task automatic d1(input logic [7:0] d);
    sv1 = 1'b1; sd1 = d;
    @(posedge clk); #1;
    sv1 = 1'b0;
  endtask

  initial begin
    reset0 = 1'b1; clear0 = 1'b0; sv0 = 1'b0; sd0 = '0;
    reset1 = 1'b1; clear1 = 1'b0; sv1 = 1'b0; sd1 = '0;
    repeat (2) @(posedge clk);
    #1;
    reset0 = 1'b0; reset1 = 1'b0;
    d0(1'b0, 0);
    expect_out(0, "reset0", 2'd0, 0, 0, 8'd0, 32'd0, 0, 0);
    expect_out(1, "reset1", 2'd0, 0, 0, 8'd0, 32'd0, 0, 0);

    // Clean run
    run0(0, 30);
    expect_out(0, "clean_hit_a", 2'd1, 1, 0, 8'd0, 32'd31, 0, 0);
    run0(31, 499);
    expect_out(0, "clean_end", 2'd2, 1, 1, 8'd0, 32'd500, 1, 0);
    run0(500, 502);
    expect_out(0, "done_hold", 2'd2, 1, 1, 8'd0, 32'd500, 1, 0);
    clr0();
    expect_out(0, "clear_done", 2'd0, 0, 0, 8'd0, 32'd0, 0, 0);

    // Single glitch
    run0(0, 40);
    d0(1'b1, 32'd45);
    expect_out(0, "glitch_at45", 2'd1, 1, 0, 8'd1, 32'd42, 0, 0);
    run0(46, 499);
    expect_out(0, "glitch_end", 2'd2, 1, 1, 8'd1, 32'd496, 1, 0);
    clr0();

    // Error limit
    for (int k = 0; k <= 7; k++) d0(1'b1, 32'(2 * k));
    expect_out(0, "errlim_7", 2'd1, 0, 0, 8'd7, 32'd8, 0, 0);
    d0(1'b1, 32'd16);
    expect_out(0, "errlim_8", 2'd3, 0, 0, 8'd8, 32'd9, 0, 1);
    d0(1'b1, 32'd18);
    d0(1'b1, 32'd20);
    expect_out(0, "fail_hold", 2'd3, 0, 0, 8'd8, 32'd9, 0, 1);
    clr0();

    // Stall
    run0(0, 10);
    repeat (14) d0(1'b0, 0);
    d0(1'b0, 0);
    expect_out(0, "stall_15", 2'd1, 0, 0, 8'd0, 32'd11, 0, 0);
    d0(1'b0, 0);
    expect_out(0, "stall_16", 2'd3, 0, 0, 8'd0, 32'd11, 0, 1);
    clr0();

    // Asynchronous reset mid-run
    run0(0, 100);
    #1 reset0 = 1'b1;
    expect_out(0, "async_reset", 2'd0, 0, 0, 8'd0, 32'd0, 0, 0);
    @(posedge clk); #1;
    reset0 = 1'b0;
    d0(1'b0, 0);
    expect_out(0, "post_reset_idle", 2'd0, 0, 0, 8'd0, 32'd0, 0, 0);
    run0(0, 20);
    expect_out(0, "restart_20", 2'd1, 0, 0, 8'd0, 32'd21, 0, 0);
    clr0();
    expect_out(0, "clear_run", 2'd0, 0, 0, 8'd0, 32'd0, 0, 0);
    run0(0, 499);
    expect_out(0, "rerun_end", 2'd2, 1, 1, 8'd0, 32'd500, 1, 0);

    // Wrap on the 8-bit instance
    d1(8'd254);
    d1(8'd255);
    expect_out(1, "wrap_255", 2'd1, 0, 1, 8'd1, 32'd2, 0, 0);
    d1(8'd0);
    d1(8'd1);
    d1(8'd2);
    d1(8'd3);
    expect_out(1, "wrap_end", 2'd2, 0, 1, 8'd1, 32'd6, 1, 0);

    repeat (3) @(posedge clk);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
